// File: rtl/bp_pkg.sv
// Shared encodings, BTB entry layout and counter helper for the gshare front-end predictor.
package bp_pkg;

  // Resolved control-flow kind presented at EX
  typedef enum logic [1:0] {
    EX_NONE = 2'b00,
    EX_JAL  = 2'b01,
    EX_BR   = 2'b10,
    EX_JALR = 2'b11
  } ex_kind_e;

  // Kind of instruction cached in a BTB entry
  typedef enum logic [1:0] {
    BT_BR   = 2'd0,
    BT_JAL  = 2'd1,
    BT_JALR = 2'd2,
    BT_RET  = 2'd3
  } btb_type_e;

  // 2-bit saturating direction counter states
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag field is sized for the smallest BTB (pc[31:2]); narrower tags are zero-extended
  localparam int unsigned TAG_W = 30;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    btb_type_e        kind;
  } btb_entry_t;

  // Saturating increment on taken, saturating decrement on not-taken
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? ctr : ctr + 2'd1;
    return (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; full pushes overwrite the oldest entry.
module bp_ras #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        nonempty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      stack [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] top_idx;
  logic             do_pop;

  assign top_idx  = ptr - PTR_W'(1);
  assign top      = stack[top_idx];
  assign nonempty = (count != '0);
  assign do_pop   = pop && nonempty;

  // Pop-then-push collapses to an in-place overwrite of the top slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (do_pop && push) begin
      stack[top_idx] <= push_data;
    end else if (do_pop) begin
      ptr   <= top_idx;
      count <= count - CNT_W'(1);
    end else if (push) begin
      stack[ptr] <= push_data;
      ptr        <= ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_gsr.sv
// Gshare direction predictor + 2-way LRU BTB + RAS, looked up at IF and trained at EX.
module branch_predictor_gsr
  import bp_pkg::*;
#(
  parameter int unsigned BTB_SETS    = 16,
  parameter int unsigned PHT_ENTRIES = 64,
  parameter int unsigned GHR_WIDTH   = 6,
  parameter int unsigned RAS_DEPTH   = 4,
  parameter logic [1:0]  CTR_INIT    = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_en,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic [1:0]  ex_kind,
  input  logic        ex_is_call,
  input  logic        ex_is_ret,
  input  logic        ex_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        ex_mispredict,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  localparam int unsigned SET_W = $clog2(BTB_SETS);
  localparam int unsigned PHT_W = $clog2(PHT_ENTRIES);

  btb_entry_t           way0 [BTB_SETS];
  btb_entry_t           way1 [BTB_SETS];
  logic                 lru  [BTB_SETS];
  logic [1:0]           pht  [PHT_ENTRIES];
  logic [GHR_WIDTH-1:0] ghr;

  logic [31:0] ras_top;
  logic        ras_nonempty;

  function automatic logic [SET_W-1:0] set_of(input logic [31:0] pc);
    return pc[SET_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    return TAG_W'(pc[31:SET_W+2]);
  endfunction

  function automatic logic [PHT_W-1:0] pht_idx(input logic [31:0] pc, input logic [GHR_WIDTH-1:0] hist);
    return pc[PHT_W+1:2] ^ PHT_W'(hist);
  endfunction

  logic [SET_W-1:0] if_set, ex_set;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic [PHT_W-1:0] if_idx, ex_idx;
  btb_entry_t       if_e0, if_e1, if_ent, ex_e0, ex_e1, new_entry;
  logic             if_hit, ex_hit0, ex_hit1, victim, upd;
  btb_type_e        new_kind;

  assign if_set = set_of(if_pc);
  assign if_tag = tag_of(if_pc);
  assign if_idx = pht_idx(if_pc, ghr);
  assign ex_set = set_of(ex_pc);
  assign ex_tag = tag_of(ex_pc);
  assign ex_idx = pht_idx(ex_pc, ghr);
  assign if_e0  = way0[if_set];
  assign if_e1  = way1[if_set];
  assign ex_e0  = way0[ex_set];
  assign ex_e1  = way1[ex_set];

  assign upd           = upd_en && (ex_kind != EX_NONE);
  assign ex_mispredict = (ex_kind != EX_NONE) &&
                         ((ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_target != ex_target)));

  // IF lookup: way 0 wins a double hit; RET entries redirect to the stack top
  always_comb begin
    if_pred_taken  = 1'b0;
    if_pred_target = '0;
    if_hit         = 1'b0;
    if_ent         = if_e0;
    if (if_e0.valid && (if_e0.tag == if_tag)) begin
      if_hit = 1'b1;
    end else if (if_e1.valid && (if_e1.tag == if_tag)) begin
      if_hit = 1'b1;
      if_ent = if_e1;
    end
    if (if_hit) begin
      case (if_ent.kind)
        BT_BR: begin
          if_pred_taken  = pht[if_idx][1];
          if_pred_target = if_ent.target;
        end
        BT_JAL, BT_JALR: begin
          if_pred_taken  = 1'b1;
          if_pred_target = if_ent.target;
        end
        BT_RET: begin
          if_pred_taken  = ras_nonempty;
          if_pred_target = ras_top;
        end
      endcase
    end
  end

  // EX side: hit detection, victim choice and the entry to be written
  always_comb begin
    ex_hit0  = ex_e0.valid && (ex_e0.tag == ex_tag);
    ex_hit1  = !ex_hit0 && ex_e1.valid && (ex_e1.tag == ex_tag);
    victim   = !ex_e0.valid ? 1'b0 : (!ex_e1.valid ? 1'b1 : lru[ex_set]);
    new_kind = BT_BR;
    if (ex_is_ret) begin
      new_kind = BT_RET;
    end else begin
      case (ex_kind)
        EX_JAL:  new_kind = BT_JAL;
        EX_JALR: new_kind = BT_JALR;
        default: new_kind = BT_BR;
      endcase
    end
    new_entry = '{valid: 1'b1, tag: ex_tag, target: ex_target, kind: new_kind};
  end

  // BTB refresh on hit, allocate on taken miss; LRU always points away from the touched way
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_SETS; i++) begin
        way0[i] <= '0;
        way1[i] <= '0;
        lru[i]  <= 1'b0;
      end
    end else if (upd && (ex_hit0 || ex_hit1 || ex_taken)) begin
      if (ex_hit0 || (!ex_hit1 && !victim)) begin
        way0[ex_set] <= new_entry;
        lru[ex_set]  <= 1'b1;
      end else begin
        way1[ex_set] <= new_entry;
        lru[ex_set]  <= 1'b0;
      end
    end
  end

  // Gshare training for conditional branches, indexed with the pre-update history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) pht[i] <= CTR_INIT;
    end else if (upd && (ex_kind == EX_BR)) begin
      pht[ex_idx] <= ctr_next(pht[ex_idx], ex_taken);
      ghr         <= {ghr[GHR_WIDTH-2:0], ex_taken};
    end
  end

  // Performance counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (upd) begin
      perf_branches <= perf_branches + 32'd1;
      if (ex_mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

  bp_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (upd && ex_is_call),
    .pop      (upd && ex_is_ret),
    .push_data(ex_pc + 32'd4),
    .top      (ras_top),
    .nonempty (ras_nonempty)
  );

endmodule

// File: tb/tb_branch_predictor_gsr.sv
// Directed table-driven bench for branch_predictor_gsr (default parameters).
module tb_branch_predictor_gsr;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_JAL  = 2'b01;
  localparam logic [1:0] K_BR   = 2'b10;
  localparam logic [1:0] K_JALR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_en;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic [1:0]  ex_kind;
  logic        ex_is_call, ex_is_ret, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_mispredict;
  logic [31:0] perf_branches, perf_mispredicts;

  branch_predictor_gsr dut (
    .clk             (clk),
    .rst             (rst),
    .upd_en          (upd_en),
    .if_pc           (if_pc),
    .if_pred_taken   (if_pred_taken),
    .if_pred_target  (if_pred_target),
    .ex_kind         (ex_kind),
    .ex_is_call      (ex_is_call),
    .ex_is_ret       (ex_is_ret),
    .ex_taken        (ex_taken),
    .ex_pc           (ex_pc),
    .ex_target       (ex_target),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_target  (ex_pred_target),
    .ex_mispredict   (ex_mispredict),
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic [1:0]  kind;
    logic        call;
    logic        ret;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        ptaken;
    logic [31:0] ptgt;
    logic [31:0] ifpc;
    logic        e_pt;
    logic [31:0] e_tgt;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(input logic upd, input logic [1:0] kind, input logic call, input logic ret,
                              input logic taken, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic ptaken, input logic [31:0] ptgt, input logic [31:0] ifpc,
                              input logic e_pt, input logic [31:0] e_tgt, input logic e_mis);
    vec_t v;
    v.upd = upd; v.kind = kind; v.call = call; v.ret = ret; v.taken = taken;
    v.pc = pc; v.tgt = tgt; v.ptaken = ptaken; v.ptgt = ptgt; v.ifpc = ifpc;
    v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_mis = e_mis;
    return v;
  endfunction

  // Lookup only, no resolution at EX
  function automatic vec_t nop(input logic [31:0] ifpc, input logic e_pt, input logic [31:0] e_tgt);
    return mk(1'b1, K_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, ifpc, e_pt, e_tgt, 1'b0);
  endfunction

  // Not-taken branch at pc 0 used to shift zeros into the history
  function automatic vec_t clr();
    return mk(1'b1, K_BR, 1'b0, 1'b0, 1'b0, 32'h0, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic idle();
    upd_en = 1'b0; ex_kind = K_NONE; ex_is_call = 1'b0; ex_is_ret = 1'b0; ex_taken = 1'b0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  // Drive each row after a falling edge, check before the next rising edge commits it
  task automatic run_tbl(input string sect);
    foreach (tbl[i]) begin
      @(negedge clk);
      upd_en = tbl[i].upd; ex_kind = tbl[i].kind; ex_is_call = tbl[i].call; ex_is_ret = tbl[i].ret;
      ex_taken = tbl[i].taken; ex_pc = tbl[i].pc; ex_target = tbl[i].tgt;
      ex_pred_taken = tbl[i].ptaken; ex_pred_target = tbl[i].ptgt; if_pc = tbl[i].ifpc;
      #1;
      chk($sformatf("%s[%0d] pred_taken", sect, i), 32'(if_pred_taken), 32'(tbl[i].e_pt));
      chk($sformatf("%s[%0d] pred_target", sect, i), if_pred_target, tbl[i].e_tgt);
      chk($sformatf("%s[%0d] mispredict", sect, i), 32'(ex_mispredict), 32'(tbl[i].e_mis));
    end
    @(negedge clk);
    idle();
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_pc = '0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and gshare training at 0x200
    tbl.push_back(nop(32'h100, 1'b0, 32'h0));
    tbl.push_back(mk(1, K_BR, 0, 0, 1, 32'h200, 32'h180, 0, 32'h0,   32'h200, 0, 32'h0,   1));
    tbl.push_back(mk(1, K_BR, 0, 0, 1, 32'h200, 32'h180, 1, 32'h180, 32'h200, 1, 32'h180, 0));
    tbl.push_back(mk(1, K_BR, 0, 0, 1, 32'h200, 32'h180, 1, 32'h180, 32'h200, 1, 32'h180, 0));
    tbl.push_back(nop(32'h200, 1'b1, 32'h180));
    run_tbl("train");
    chk("train perf_branches", perf_branches, 32'd3);
    chk("train perf_mispredicts", perf_mispredicts, 32'd1);

    // upd_en=0: mispredict still evaluated, nothing updated
    tbl.push_back(mk(0, K_BR,   0, 0, 1, 32'h200, 32'h180, 1, 32'h184, 32'h200, 1, 32'h180, 1));
    tbl.push_back(mk(0, K_BR,   0, 0, 0, 32'h200, 32'h180, 0, 32'h999, 32'h200, 1, 32'h180, 0));
    tbl.push_back(mk(0, K_NONE, 0, 0, 1, 32'h200, 32'h180, 0, 32'h0,   32'h200, 1, 32'h180, 0));
    tbl.push_back(mk(0, K_JALR, 0, 0, 1, 32'h200, 32'h240, 1, 32'h240, 32'h200, 1, 32'h180, 0));
    tbl.push_back(mk(0, K_BR,   0, 0, 0, 32'h200, 32'h180, 1, 32'h180, 32'h200, 1, 32'h180, 1));
    tbl.push_back(mk(0, K_JAL,  0, 0, 1, 32'h600, 32'h700, 0, 32'h0,   32'h600, 0, 32'h0,   1));
    tbl.push_back(nop(32'h600, 1'b0, 32'h0));
    tbl.push_back(nop(32'h200, 1'b1, 32'h180));
    run_tbl("noupd");
    chk("noupd perf_branches", perf_branches, 32'd3);
    chk("noupd perf_mispredicts", perf_mispredicts, 32'd1);

    // Asynchronous reset after training, held across an edge with a live update
    @(negedge clk);
    rst = 1'b1; upd_en = 1'b1; ex_kind = K_BR; ex_taken = 1'b1; ex_pc = 32'h200;
    ex_target = 32'h180; ex_pred_taken = 1'b0; if_pc = 32'h200;
    #1;
    chk("rst pred_taken", 32'(if_pred_taken), 32'd0);
    chk("rst pred_target", if_pred_target, 32'h0);
    chk("rst perf_branches", perf_branches, 32'd0);
    chk("rst perf_mispredicts", perf_mispredicts, 32'd0);
    chk("rst mispredict", 32'(ex_mispredict), 32'd1);
    @(negedge clk);
    #1;
    chk("rst held pred_taken", 32'(if_pred_taken), 32'd0);
    chk("rst held perf_branches", perf_branches, 32'd0);
    rst = 1'b0;
    idle();

    // Set-0 conflicts: LRU eviction, hit refreshes LRU, no-bypass, NT miss does not allocate
    tbl.push_back(mk(1, K_JAL, 0, 0, 1, 32'h040, 32'h1000, 0, 32'h0,    32'h040, 0, 32'h0,    1));
    tbl.push_back(mk(1, K_JAL, 0, 0, 1, 32'h440, 32'h2000, 0, 32'h0,    32'h440, 0, 32'h0,    1));
    tbl.push_back(nop(32'h040, 1'b1, 32'h1000));
    tbl.push_back(nop(32'h440, 1'b1, 32'h2000));
    tbl.push_back(mk(1, K_JAL, 0, 0, 1, 32'h840, 32'h3000, 0, 32'h0,    32'h840, 0, 32'h0,    1));
    tbl.push_back(nop(32'h040, 1'b0, 32'h0));
    tbl.push_back(nop(32'h440, 1'b1, 32'h2000));
    tbl.push_back(nop(32'h840, 1'b1, 32'h3000));
    tbl.push_back(mk(1, K_JAL, 0, 0, 1, 32'h440, 32'h2400, 1, 32'h2000, 32'h440, 1, 32'h2000, 1));
    tbl.push_back(mk(1, K_JAL, 0, 0, 1, 32'hC40, 32'h4000, 0, 32'h0,    32'hC40, 0, 32'h0,    1));
    tbl.push_back(nop(32'h440, 1'b1, 32'h2400));
    tbl.push_back(nop(32'h840, 1'b0, 32'h0));
    tbl.push_back(nop(32'hC40, 1'b1, 32'h4000));
    tbl.push_back(mk(1, K_BR,  0, 0, 0, 32'h080, 32'h0090, 0, 32'h0,    32'h080, 0, 32'h0,    0));
    tbl.push_back(nop(32'h080, 1'b0, 32'h0));
    run_tbl("btb");

    // Return-address stack: basic call/ret, overflow, underflow, call+ret combos
    do_reset();
    tbl.push_back(mk(1, K_JAL,  1, 0, 1, 32'h300,  32'h800,  0, 32'h0,    32'h300, 0, 32'h0,    1));
    tbl.push_back(mk(1, K_JALR, 0, 1, 1, 32'h500,  32'h304,  0, 32'h0,    32'h500, 0, 32'h0,    1));
    tbl.push_back(mk(1, K_JAL,  1, 0, 1, 32'h300,  32'h800,  1, 32'h800,  32'h500, 0, 32'h0,    0));
    tbl.push_back(nop(32'h500, 1'b1, 32'h304));
    tbl.push_back(mk(1, K_JALR, 0, 1, 1, 32'h500,  32'h304,  1, 32'h304,  32'h500, 1, 32'h304,  0));
    tbl.push_back(mk(1, K_JAL,  1, 0, 1, 32'h1004, 32'h2000, 0, 32'h0,    32'h500, 0, 32'h0,    1));
    tbl.push_back(mk(1, K_JAL,  1, 0, 1, 32'h1008, 32'h2000, 0, 32'h0,    32'h500, 1, 32'h1008, 1));
    tbl.push_back(mk(1, K_JAL,  1, 0, 1, 32'h100C, 32'h2000, 0, 32'h0,    32'h500, 1, 32'h100C, 1));
    tbl.push_back(mk(1, K_JAL,  1, 0, 1, 32'h1014, 32'h2000, 0, 32'h0,    32'h500, 1, 32'h1010, 1));
    tbl.push_back(mk(1, K_JAL,  1, 0, 1, 32'h1018, 32'h2000, 0, 32'h0,    32'h500, 1, 32'h1018, 1));
    tbl.push_back(mk(1, K_JALR, 0, 1, 1, 32'h500,  32'h101C, 1, 32'h101C, 32'h500, 1, 32'h101C, 0));
    tbl.push_back(mk(1, K_JALR, 0, 1, 1, 32'h500,  32'h1018, 1, 32'h1018, 32'h500, 1, 32'h1018, 0));
    tbl.push_back(mk(1, K_JALR, 0, 1, 1, 32'h500,  32'h1010, 1, 32'h1010, 32'h500, 1, 32'h1010, 0));
    tbl.push_back(mk(1, K_JALR, 0, 1, 1, 32'h500,  32'h100C, 1, 32'h100C, 32'h500, 1, 32'h100C, 0));
    tbl.push_back(mk(1, K_JALR, 0, 1, 1, 32'h500,  32'h1008, 0, 32'h101C, 32'h500, 0, 32'h101C, 1));
    tbl.push_back(nop(32'h500, 1'b0, 32'h101C));
    tbl.push_back(mk(1, K_JALR, 1, 1, 1, 32'h608,  32'h900,  0, 32'h0,    32'h500, 0, 32'h101C, 1));
    tbl.push_back(nop(32'h500, 1'b1, 32'h60C));
    tbl.push_back(mk(1, K_JAL,  1, 0, 1, 32'h1004, 32'h2000, 1, 32'h2000, 32'h500, 1, 32'h60C,  0));
    tbl.push_back(mk(1, K_JALR, 1, 1, 1, 32'h70C,  32'h900,  0, 32'h0,    32'h500, 1, 32'h1008, 1));
    tbl.push_back(mk(1, K_JALR, 0, 1, 1, 32'h500,  32'h710,  1, 32'h710,  32'h500, 1, 32'h710,  0));
    tbl.push_back(mk(1, K_JALR, 0, 1, 1, 32'h500,  32'h60C,  1, 32'h60C,  32'h500, 1, 32'h60C,  0));
    tbl.push_back(nop(32'h500, 1'b0, 32'h101C));
    tbl.push_back(mk(0, K_JAL,  1, 0, 1, 32'h1004, 32'h2000, 1, 32'h2000, 32'h500, 0, 32'h101C, 0));
    tbl.push_back(nop(32'h500, 1'b0, 32'h101C));
    run_tbl("ras");

    // Counter saturation at 11 and 00 on PHT[0], history cleared to zero between probes
    do_reset();
    tbl.push_back(mk(1, K_BR, 0, 0, 1, 32'h200, 32'h180, 0, 32'h0,   32'h200, 0, 32'h0,   1));
    for (int i = 0; i < 6; i++) tbl.push_back(clr());
    tbl.push_back(nop(32'h200, 1'b1, 32'h180));
    tbl.push_back(mk(1, K_BR, 0, 0, 1, 32'h200, 32'h180, 1, 32'h180, 32'h200, 1, 32'h180, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(clr());
    tbl.push_back(mk(1, K_BR, 0, 0, 0, 32'h200, 32'h180, 1, 32'h180, 32'h200, 1, 32'h180, 1));
    tbl.push_back(nop(32'h200, 1'b1, 32'h180));
    tbl.push_back(mk(1, K_BR, 0, 0, 0, 32'h200, 32'h180, 1, 32'h180, 32'h200, 1, 32'h180, 1));
    tbl.push_back(nop(32'h200, 1'b0, 32'h180));
    tbl.push_back(mk(1, K_BR, 0, 0, 0, 32'h200, 32'h180, 0, 32'h180, 32'h200, 0, 32'h180, 0));
    tbl.push_back(mk(1, K_BR, 0, 0, 0, 32'h200, 32'h180, 0, 32'h180, 32'h200, 0, 32'h180, 0));
    tbl.push_back(mk(1, K_BR, 0, 0, 1, 32'h200, 32'h180, 0, 32'h180, 32'h200, 0, 32'h180, 1));
    for (int i = 0; i < 6; i++) tbl.push_back(clr());
    tbl.push_back(nop(32'h200, 1'b0, 32'h180));
    run_tbl("sat");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
